debug_tx_serializer: RTL and testbench
======================================

// Module: debug_tx_serializer
// PURPOSE
//  Consumes the wide pipeline-state snapshot from the MIPS core (o_to_debug bus) and streams it
//  byte-by-byte to the UART transmitter. Sits inside the debug path between the MIPS datapath
//  and the UART TX: the snapshot is captured on a start request, and each byte is handed off with
//  a start/done handshake. The debug unit calls it on each step and on halt (stop signal).
// PARAMETERS
//  DATA_W   2558  width of snapshot bus from MIPS
//  BYTE_W   8     UART payload width
//  NBYTES   derived = ceil(DATA_W/BYTE_W) (320 at default); localparam, not overridable
// PORTS
//  clk         in   1             system clock; single clock domain
//  rst         in   1             synchronous, active-high reset
//  i_start     in   1             request: capture i_data and begin a transfer (sampled in IDLE only)
//  i_data      in   DATA_W        snapshot bus from MIPS
//  i_tx_done   in   1             1-cycle tick from UART TX: current byte fully shifted out
//  o_tx_start  out  1             1-cycle pulse: UART TX loads o_tx_byte
//  o_tx_byte   out  BYTE_W        byte being transmitted
//  o_busy      out  1             high from capture until o_done pulse inclusive
//  o_done      out  1             1-cycle pulse after last byte's i_tx_done
// BEHAVIOUR
//  - All outputs registered. Reset values: o_tx_start=0, o_tx_byte=0, o_busy=0, o_done=0;
//    state=IDLE, byte counter=0, shadow register=0.
//  - Shadow register width NBYTES*BYTE_W; on capture loads {zero pad, i_data} (pad bits in MSBs = 0).
//  - Byte order: LSB first; byte k = shadow bits [8k+7:8k]; last byte carries pad bits.
//  - FSM (Moore):
//    IDLE : i_start=1 -> capture shadow, cnt=0, o_busy=1 -> SEND.  Otherwise stay.
//    SEND : one cycle; o_tx_start=1, o_tx_byte=shadow[7:0] -> WAIT.
//    WAIT : o_tx_start=0, o_tx_byte held stable. On i_tx_done:
//           cnt==NBYTES-1 -> DONE; else shift shadow right BYTE_W, cnt++ -> SEND.
//    DONE : one cycle; o_done=1, o_busy=1 -> IDLE (o_busy=0 next cycle).
//  - Latency: i_start sampled at edge k -> o_tx_start high in cycle after edge k+1 (SEND);
//    i_tx_done at edge m -> next o_tx_start one cycle later. Total: NBYTES o_tx_start pulses.
//  - Boundaries:
//    i_start while not IDLE: ignored, snapshot not re-captured, no queuing.
//    i_start in DONE cycle: ignored (accepted only when state==IDLE).
//    i_tx_done in IDLE/SEND/DONE: ignored; counter never advances without WAIT.
//    i_tx_done held high multiple cycles: each WAIT consumes one tick only (SEND between).
//    i_data changing mid-transfer: no effect; shadow is the only source.
//    rst mid-transfer: next cycle IDLE, all outputs at reset values, no further o_tx_start.
//    Counter width $clog2(NBYTES); never exceeds NBYTES-1 (no wrap).
// STRUCTURE
//  - Shared package debug_pkg: BYTE_W, function nbytes(DATA_W), FSM state encoding
//    (IDLE/SEND/WAIT/DONE, 2-bit), snapshot width constant shared with MIPS and debug_unit.
//  - Single module; byte counter optionally split into sub-module tx_byte_counter
//    (load/inc/terminal-count). Shadow shift register and FSM stay in this module.
// TESTING
//  1. Reset: rst=1 for 3 cycles mid-WAIT -> all outputs 0, state IDLE, no o_tx_start after release.
//  2. Full transfer: i_data = byte k set to k[7:0] pattern, i_start pulse, TX model returns
//     i_tx_done 10 cycles after each o_tx_start -> 320 bytes 0x00,0x01..0xFF,0x00..; last byte
//     upper 2 bits 0 (pad); o_done once, o_busy low afterwards.
//  3. Snapshot isolation: i_start with i_data=all 1s, then drive i_data=0 -> all bytes 0xFF
//     except last = 0x3F.
//  4. Ignored start: i_start pulses during WAIT and DONE -> no restart, exactly 320 o_tx_start.
//  5. Spurious done: i_tx_done in IDLE and in SEND cycle -> counter unchanged, no skipped byte;
//     i_tx_done held 5 cycles -> advances exactly one byte per WAIT.
//  6. Back-to-back: i_start in first IDLE cycle after o_done -> second transfer starts, o_tx_start
//     two cycles after i_start.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared definitions for the MIPS debug path: payload width, snapshot width,
// byte-count helper and the TX serializer FSM encoding.
package debug_pkg;

    localparam int unsigned DBG_BYTE_W     = 8;
    localparam int unsigned DBG_SNAPSHOT_W = 2558;

    // Number of payload bytes needed to carry data_w bits (rounded up).
    function automatic int unsigned nbytes(input int unsigned data_w,
                                           input int unsigned byte_w = DBG_BYTE_W);
        return (data_w + byte_w - 1) / byte_w;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_byte_counter.sv
// Byte index counter for the TX serializer: cleared on load, advanced on inc,
// saturating at MAX-1 with a terminal-count flag.
module tx_byte_counter #(
    parameter int unsigned MAX   = 320,
    parameter int unsigned CNT_W = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    assign tc_o = (cnt_q == CNT_W'(MAX - 1));

    // Counter register; never advances past the terminal value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (inc_i && !tc_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_tx_serializer.sv
// Captures the MIPS pipeline snapshot on request and streams it LSB-byte-first
// to the UART transmitter using a start/done handshake per byte.
module debug_tx_serializer
    import debug_pkg::*;
#(
    parameter int unsigned DATA_W = DBG_SNAPSHOT_W,
    parameter int unsigned BYTE_W = DBG_BYTE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [BYTE_W-1:0] o_tx_byte,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned NBYTES   = nbytes(DATA_W, BYTE_W);
    localparam int unsigned SHADOW_W = NBYTES * BYTE_W;
    localparam int unsigned CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    tx_state_e           state_q, state_d;
    logic [SHADOW_W-1:0] shadow_q, shadow_d;
    logic                tx_start_q, tx_start_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cnt_load, cnt_inc, cnt_tc;

    tx_byte_counter #(
        .MAX   (NBYTES),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .tc_o   (cnt_tc)
    );

    // Next-state and next-output logic. Outputs are registered, so each
    // pulse appears one cycle after the state that requests it; busy is held
    // through the DONE state and cleared from IDLE, which keeps it high
    // during the visible o_done cycle.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        tx_start_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    shadow_d = SHADOW_W'(i_data);
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_start_d = 1'b1;
                tx_byte_d  = shadow_q[BYTE_W-1:0];
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (cnt_tc) begin
                        state_d = ST_DONE;
                    end else begin
                        shadow_d = shadow_q >> BYTE_W;
                        cnt_inc  = 1'b1;
                        state_d  = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, shadow snapshot and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_byte  = tx_byte_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_debug_tx_serializer.sv
// Directed bench for debug_tx_serializer: reset, full transfer, snapshot
// isolation, ignored starts, spurious/held done ticks and back-to-back runs.
module tb_debug_tx_serializer;

    localparam int unsigned DATA_W = 2558;
    localparam int NB = 320;

    logic              clk;
    logic              rst;
    logic              i_start;
    logic [DATA_W-1:0] i_data;
    logic              i_tx_done;
    logic              o_tx_start;
    logic [7:0]        o_tx_byte;
    logic              o_busy;
    logic              o_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] got[$];
    int dones = 0;

    debug_tx_serializer #(
        .DATA_W (DATA_W),
        .BYTE_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_data     (i_data),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_byte  (o_tx_byte),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every transmitted byte and every o_done pulse.
    always @(negedge clk) begin
        if (o_tx_start === 1'b1) got.push_back(o_tx_byte);
        if (o_done === 1'b1) dones++;
    end

    function automatic logic [7:0] pat(input int mode, input int k);
        int v;
        case (mode)
            0: v = k;
            1: v = k * 3;
            2: v = k ^ 'hA5;
            3: v = k + 7;
            default: v = 255;
        endcase
        return v[7:0];
    endfunction

    // Last byte only carries 6 real bits (2558 = 319*8 + 6); upper two are pad.
    function automatic logic [7:0] exp_byte(input int mode, input int k);
        logic [7:0] b;
        b = pat(mode, k);
        if (k == NB - 1) b = b & 8'h3F;
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] make_data(input int mode);
        logic [NB*8-1:0] tmp;
        for (int k = 0; k < NB; k++) tmp[k*8 +: 8] = pat(mode, k);
        return tmp[DATA_W-1:0];
    endfunction

    task automatic wait_start(output bit to);
        to = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            if (o_tx_start === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    // UART TX model: answers each o_tx_start with a one-cycle i_tx_done ten
    // cycles later, optionally poking i_start during WAIT / DONE; returns in
    // the cycle o_done is visible.
    task automatic serve(input int n, input bit first_seen, input bit start_in_wait,
                         input bit start_in_done, output bit to);
        bit t;
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!(i == 0 && first_seen)) begin
                wait_start(t);
                if (t) begin
                    to = 1'b1;
                    return;
                end
            end
            for (int c = 0; c < 9; c++) begin
                @(posedge clk); #1;
                i_start = start_in_wait && (i % 64 == 5) && (c == 3);
            end
            @(posedge clk); #1; i_tx_done = 1'b1;
            @(posedge clk); #1; i_tx_done = 1'b0;
            i_start = start_in_done && (i == n - 1);
        end
        to = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            if (o_done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit t;
        rst = 1'b1; i_start = 1'b0; i_tx_done = 1'b0; i_data = '0;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_init_start: got %b want 0", o_tx_start); end
        n_checks++; if (o_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_init_byte: got %h want 00", o_tx_byte); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_init_busy: got %b want 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", o_done); end
        rst = 1'b0;
        i_data = make_data(4); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        wait_start(t);
        n_checks++; if (t) begin n_fail++; $display("FAIL rst_first_start: timeout waiting for o_tx_start"); end
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start: got %b want 0", o_tx_start); end
        n_checks++; if (o_tx_byte !== 8'h00) begin n_fail++; $display("FAIL rst_mid_byte: got %h want 00", o_tx_byte); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", o_busy); end
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", o_done); end
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        got.delete(); dones = 0;
        i_tx_done = 1'b1;
        repeat (30) @(posedge clk); #1;
        i_tx_done = 1'b0;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL rst_no_start: got %0d pulses want 0", got.size()); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_full_transfer();
        bit t;
        logic [7:0] act, exp;
        got.delete(); dones = 0;
        i_data = make_data(0); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_capture: got %b want 1", o_busy); end
        n_checks++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL full_start_early: got %b want 0", o_tx_start); end
        @(posedge clk); #1;
        n_checks++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL full_start_latency: got %b want 1", o_tx_start); end
        serve(NB, 1'b1, 1'b0, 1'b0, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL full_timeout: transfer did not complete"); end
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_at_done: got %b want 1", o_busy); end
        @(posedge clk); #1;
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %b want 0", o_busy); end
        repeat (5) @(posedge clk); #1;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", dones); end
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL full_byte_count: got %0d want %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            exp = exp_byte(0, k);
            act = (k < got.size()) ? got[k] : 8'hxx;
            n_checks++; if (act !== exp) begin n_fail++; $display("FAIL full_byte[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_snapshot_isolation();
        bit t;
        logic [7:0] act, exp;
        got.delete(); dones = 0;
        i_data = make_data(4); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0; i_data = '0;
        serve(NB, 1'b0, 1'b0, 1'b0, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL iso_timeout: transfer did not complete"); end
        repeat (5) @(posedge clk); #1;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL iso_done_count: got %0d want 1", dones); end
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL iso_byte_count: got %0d want %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            exp = exp_byte(4, k);
            act = (k < got.size()) ? got[k] : 8'hxx;
            n_checks++; if (act !== exp) begin n_fail++; $display("FAIL iso_byte[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_ignored_start();
        bit t;
        logic [7:0] act, exp;
        got.delete(); dones = 0;
        i_data = make_data(1); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0; i_data = '0;
        serve(NB, 1'b0, 1'b1, 1'b1, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL ign_timeout: transfer did not complete"); end
        repeat (40) @(posedge clk); #1;
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL ign_byte_count: got %0d want %0d", got.size(), NB); end
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", dones); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_after: got %b want 0", o_busy); end
        for (int k = 0; k < NB; k++) begin
            exp = exp_byte(1, k);
            act = (k < got.size()) ? got[k] : 8'hxx;
            n_checks++; if (act !== exp) begin n_fail++; $display("FAIL ign_byte[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_spurious_done();
        bit t;
        logic [7:0] act, exp;
        got.delete(); dones = 0;
        i_tx_done = 1'b1;
        repeat (3) @(posedge clk); #1;
        i_tx_done = 1'b0;
        n_checks++; if (got.size() != 0) begin n_fail++; $display("FAIL spur_idle_start: got %0d pulses want 0", got.size()); end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL spur_idle_busy: got %b want 0", o_busy); end
        i_data = make_data(2); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0; i_tx_done = 1'b1;
        @(posedge clk); #1; i_tx_done = 1'b0;
        n_checks++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL spur_send_start: got %b want 1", o_tx_start); end
        n_checks++; if (o_tx_byte !== exp_byte(2, 0)) begin n_fail++; $display("FAIL spur_send_byte: got %h want %h", o_tx_byte, exp_byte(2, 0)); end
        repeat (3) @(posedge clk); #1;
        i_tx_done = 1'b1;
        repeat (5) @(posedge clk);
        #1; i_tx_done = 1'b0;
        n_checks++; if (got.size() != 3) begin n_fail++; $display("FAIL spur_hold_count: got %0d pulses want 3", got.size()); end
        n_checks++; if (o_tx_byte !== exp_byte(2, 2)) begin n_fail++; $display("FAIL spur_hold_byte: got %h want %h", o_tx_byte, exp_byte(2, 2)); end
        serve(NB - 3, 1'b0, 1'b0, 1'b0, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL spur_timeout: transfer did not complete"); end
        repeat (5) @(posedge clk); #1;
        n_checks++; if (dones != 1) begin n_fail++; $display("FAIL spur_done_count: got %0d want 1", dones); end
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL spur_byte_count: got %0d want %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            exp = exp_byte(2, k);
            act = (k < got.size()) ? got[k] : 8'hxx;
            n_checks++; if (act !== exp) begin n_fail++; $display("FAIL spur_byte[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    task automatic test_back_to_back();
        bit t;
        logic [7:0] act, exp;
        got.delete(); dones = 0;
        i_data = make_data(0); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        serve(NB, 1'b0, 1'b0, 1'b0, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL b2b_first_timeout: transfer did not complete"); end
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL b2b_first_count: got %0d want %0d", got.size(), NB); end
        got.delete();
        @(posedge clk); #1;
        i_data = make_data(3); i_start = 1'b1;
        @(posedge clk); #1; i_start = 1'b0;
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_capture: got %b want 1", o_busy); end
        n_checks++; if (o_tx_start !== 1'b0) begin n_fail++; $display("FAIL b2b_start_early: got %b want 0", o_tx_start); end
        @(posedge clk); #1;
        n_checks++; if (o_tx_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start_latency: got %b want 1", o_tx_start); end
        n_checks++; if (o_tx_byte !== exp_byte(3, 0)) begin n_fail++; $display("FAIL b2b_first_byte: got %h want %h", o_tx_byte, exp_byte(3, 0)); end
        serve(NB, 1'b1, 1'b0, 1'b0, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL b2b_second_timeout: transfer did not complete"); end
        repeat (5) @(posedge clk); #1;
        n_checks++; if (dones != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", dones); end
        n_checks++; if (got.size() != NB) begin n_fail++; $display("FAIL b2b_second_count: got %0d want %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            exp = exp_byte(3, k);
            act = (k < got.size()) ? got[k] : 8'hxx;
            n_checks++; if (act !== exp) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h want %h", k, act, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_snapshot_isolation();
        test_ignored_start();
        test_spurious_done();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
